mmio_timer_bridge: RTL and testbench
====================================

Name: mmio_timer_bridge

Overview:
- Sits directly downstream of the pipelined CPU's M-stage data port and consumes its data address, write data and byte enables; supplies the read data the CPU latches into W.
- Decodes each access to either the external data memory (pass-through) or an internal memory-mapped countdown timer.
- The timer raises an interrupt request line for later exception support.

Parameters:
- DM_BASE, 32'h0000_0000, first byte address mapped to data memory
- DM_LIMIT, 32'h0000_2FFF, last byte address mapped to data memory (inclusive)
- TMR_BASE, 32'h0000_7F00, base of the 3-word timer register block
- CNT_W, 32, width of PRESET and COUNT registers

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; all state cleared while low
- cpu_addr  in  32  CPU data address (M stage)
- cpu_wdata  in  32  CPU write data, already lane-aligned
- cpu_byteen  in  4  CPU byte write enables; 4'b0000 means read/no write
- cpu_rdata  out  32  read data to CPU, combinational
- dm_addr  out  32  address to data memory
- dm_wdata  out  32  write data to data memory
- dm_byteen  out  4  byte enables to data memory
- dm_rdata  in  32  data memory read data, combinational
- irq  out  1  timer interrupt request

Behaviour:
- Decode (combinational): sel_dm = DM_BASE<=cpu_addr<=DM_LIMIT; sel_tmr = cpu_addr[31:4]==TMR_BASE[31:4] and cpu_addr[3:2]!=2'b11; otherwise unmapped.
- dm_addr = cpu_addr and dm_wdata = cpu_wdata, always.
- dm_byteen = cpu_byteen when sel_dm, else 4'b0000.
- cpu_rdata: sel_dm -> dm_rdata; sel_tmr -> the selected register; unmapped -> 32'h0.
- Timer registers, word offsets:
  - 0x0 CTRL: bits [0] EN, [2:1] MODE, [3] IM; bits [31:4] read 0.
  - 0x4 PRESET: read/write.
  - 0x8 COUNT: read-only.
- Timer writes are accepted only when cpu_byteen==4'b1111; partial-byte writes are ignored. Writes to COUNT and unmapped writes are ignored. Writes take effect at the next rising edge.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0. Outputs under reset: irq=0, dm_byteen follows decode.
- FSM, one transition per edge:
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: EN=0 -> IDLE, COUNT frozen. Else COUNT<=1 -> COUNT<=0, irq_flag<=1, -> INT. Else COUNT<=COUNT-1.
  - INT, MODE!=2'b01 (one-shot): EN<=0 -> IDLE; irq_flag held until CTRL or PRESET is written.
  - INT, MODE==2'b01 (auto-reload): irq_flag<=0 -> LOAD, giving a one-cycle pulse.
- irq = irq_flag & IM.
- Timing: EN written at edge 0 with PRESET=N>=1 -> COUNT=N after edge 2, irq high after edge 2+N. PRESET=0 -> irq after edge 3. Auto-reload period is N+2 cycles.
- Simultaneous events: a CPU CTRL write in the INT cycle wins over the FSM clearing EN. A CTRL or PRESET write clears irq_flag in the same edge unless the FSM is setting it that edge; set wins.
- A PRESET write during CNT does not change COUNT until the next LOAD.
- COUNT never wraps below 0.
- reset asserted mid-count -> immediate return to reset values, irq drops asynchronously.

Decomposition:
- Shared package holds:
  - address constants DM_BASE, DM_LIMIT, TMR_BASE
  - register offsets CTRL_OFF, PRESET_OFF, COUNT_OFF
  - CTRL bit indices EN_BIT, MODE_LSB/MSB, IM_BIT
  - mode encodings MODE_ONESHOT, MODE_RELOAD
  - enumerated FSM state type {IDLE, LOAD, CNT, INT}
- One sub-module, timer_core: register file, FSM and irq logic, with inputs we/offset/wdata and outputs rdata/irq.
- Top module holds decode and the read mux only.

Test Plan:
- Write 0x1234_5678, byteen 1111, to 0x0000_0010, then read 0x10 -> dm_byteen=1111 on the write; cpu_rdata=dm_rdata on the read. Write to 0x0000_4000 -> dm_byteen=0000 and read returns 0.
- PRESET=3, CTRL=0x9 (EN, one-shot, IM) -> COUNT reads 3,2,1,0 on successive cycles; irq rises after edge 5; EN reads 0 afterwards; irq stays high until a CTRL write of 0x8, then drops.
- PRESET=2, CTRL=0xB (auto-reload, IM) -> irq one-cycle pulses every 4 cycles; IM=0 -> irq stays 0 while the internal flag still toggles.
- Partial write, byteen 0011, to CTRL -> CTRL unchanged. Write to COUNT -> COUNT unchanged. Read of offset 0xC -> 0.
- CTRL EN cleared mid-count with COUNT=5 -> state IDLE, COUNT holds 5. Re-enable -> reloads PRESET.
- reset pulled low while COUNT=7 in CNT -> CTRL/PRESET/COUNT read 0 and irq=0 immediately; no irq after reset releases.

Source files
------------

// File: rtl/mmio_timer_bridge_pkg.sv
// Shared constants and types for the MMIO bridge: address map, timer register
// offsets, CTRL bit positions, mode encodings and the timer FSM state type.
package mmio_timer_bridge_pkg;

  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT = 32'h0000_2FFF;
  localparam logic [31:0] TMR_BASE = 32'h0000_7F00;
  localparam int          CNT_W    = 32;

  // Word offsets within the timer block, i.e. cpu_addr[3:2]
  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;

  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int MODE_MSB = 2;
  localparam int IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tmr_state_e;

endpackage

// File: rtl/mmio_timer_bridge_timer_core.sv
// Countdown timer: CTRL/PRESET/COUNT registers, the IDLE/LOAD/CNT/INT FSM and
// the masked interrupt request. Handshake: we is a single-cycle write strobe.
module mmio_timer_bridge_timer_core
  import mmio_timer_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output tmr_state_e  dbg_state,
  output logic        dbg_irq_flag
);

  logic [IM_BIT:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  tmr_state_e       state_q, state_d;
  logic             irq_flag_q, irq_flag_d;
  logic             set_flag;
  logic             wr_ctrl, wr_preset;

  assign wr_ctrl   = we && (offset == CTRL_OFF);
  assign wr_preset = we && (offset == PRESET_OFF);

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    irq_flag_d = irq_flag_q;
    set_flag   = 1'b0;

    case (state_q)
      IDLE: if (ctrl_q[EN_BIT]) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[EN_BIT]) begin
          state_d = IDLE;
        end else if (count_q <= CNT_W'(1)) begin
          // A zero preset lands here too, so COUNT never wraps
          count_d  = '0;
          set_flag = 1'b1;
          state_d  = INT;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      INT: begin
        if (ctrl_q[MODE_MSB:MODE_LSB] == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          ctrl_d[EN_BIT] = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // CPU writes override the FSM's EN clear; a flag set in the same edge wins
    if (wr_ctrl)   ctrl_d   = wdata[IM_BIT:0];
    if (wr_preset) preset_d = wdata[CNT_W-1:0];
    if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;
    if (set_flag) irq_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      CTRL_OFF:   rdata[IM_BIT:0]  = ctrl_q;
      PRESET_OFF: rdata[CNT_W-1:0] = preset_q;
      COUNT_OFF:  rdata[CNT_W-1:0] = count_q;
      default:    rdata = '0;
    endcase
  end

  assign irq          = irq_flag_q & ctrl_q[IM_BIT];
  assign dbg_state    = state_q;
  assign dbg_irq_flag = irq_flag_q;

endmodule

// File: rtl/mmio_timer_bridge.sv
// M-stage data port bridge: decodes each access to data memory (pass-through),
// the timer register block, or nothing, and muxes read data back to the CPU.
module mmio_timer_bridge
  import mmio_timer_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  output logic        irq
);

  logic        sel_dm;
  logic        sel_tmr;
  logic        tmr_we;
  logic [31:0] tmr_rdata;
  tmr_state_e  tmr_state_unused;
  logic        tmr_flag_unused;

  // Offset compare keeps the lower bound meaningful even when DM_BASE is zero
  assign sel_dm  = (cpu_addr - DM_BASE) <= (DM_LIMIT - DM_BASE);
  assign sel_tmr = (cpu_addr[31:4] == TMR_BASE[31:4]) && (cpu_addr[3:2] != 2'b11);
  assign tmr_we  = sel_tmr && (cpu_byteen == 4'b1111);

  assign dm_addr   = cpu_addr;
  assign dm_wdata  = cpu_wdata;
  assign dm_byteen = sel_dm ? cpu_byteen : 4'b0000;

  always_comb begin
    cpu_rdata = 32'h0;
    if (sel_dm)       cpu_rdata = dm_rdata;
    else if (sel_tmr) cpu_rdata = tmr_rdata;
  end

  mmio_timer_bridge_timer_core u_timer_core (
    .clk          (clk),
    .reset        (reset),
    .we           (tmr_we),
    .offset       (cpu_addr[3:2]),
    .wdata        (cpu_wdata),
    .rdata        (tmr_rdata),
    .irq          (irq),
    .dbg_state    (tmr_state_unused),
    .dbg_irq_flag (tmr_flag_unused)
  );

endmodule

// File: tb/tb_mmio_timer_bridge.sv
// Bench for mmio_timer_bridge: decode vector table, randomized accesses against
// a register/address-map model, and cycle-exact timer sequences.
module tb_mmio_timer_bridge;

  localparam logic [31:0] TMR  = 32'h0000_7F00;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_byteen;
  logic        irq;

  int n_vec = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mmio_timer_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_rdata  (cpu_rdata),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_byteen  (dm_byteen),
    .dm_rdata   (dm_rdata),
    .irq        (irq)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] dmr;
    logic [3:0]  exp_be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_bus();
    cpu_addr   = IDLE_ADDR;
    cpu_wdata  = 32'h0;
    cpu_byteen = 4'b0000;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the write lands on the following rising edge
  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_addr   = a;
    cpu_wdata  = d;
    cpu_byteen = be;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic read_tmr(input logic [1:0] off, output logic [31:0] v);
    cpu_addr   = TMR | {28'h0, off, 2'b00};
    cpu_byteen = 4'b0000;
    #1;
    v = cpu_rdata;
    cpu_addr = IDLE_ADDR;
  endtask

  task automatic check_regs_zero(input string tag);
    logic [31:0] v;
    read_tmr(2'd0, v); check({tag, " ctrl"}, v, 32'h0);
    read_tmr(2'd1, v); check({tag, " preset"}, v, 32'h0);
    read_tmr(2'd2, v); check({tag, " count"}, v, 32'h0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle_bus();
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [3:0]  ctrl_m;
    logic [31:0] preset_m;

    tbl[0]  = '{32'h0000_0010, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
    tbl[1]  = '{32'h0000_0010, 32'h0,         4'h0, 32'h1234_5678, 4'h0, 32'h1234_5678};
    tbl[2]  = '{32'h0000_4000, 32'h1111_2222, 4'hF, 32'hAAAA_5555, 4'h0, 32'h0};
    tbl[3]  = '{32'h0000_2FFF, 32'h0000_00FF, 4'h3, 32'h0BAD_F00D, 4'h3, 32'h0BAD_F00D};
    tbl[4]  = '{32'h0000_3000, 32'h3333_3333, 4'hF, 32'h0000_CAFE, 4'h0, 32'h0};
    tbl[5]  = '{32'h0000_0000, 32'h8000_0000, 4'h8, 32'h0000_0001, 4'h8, 32'h0000_0001};
    tbl[6]  = '{32'h0000_7F00, 32'h0,         4'h0, 32'h5A5A_5A5A, 4'h0, 32'h0};
    tbl[7]  = '{32'h0000_7F04, 32'h0,         4'h0, 32'h5A5A_5A5A, 4'h0, 32'h0};
    tbl[8]  = '{32'h0000_7F08, 32'h0,         4'h0, 32'h5A5A_5A5A, 4'h0, 32'h0};
    tbl[9]  = '{32'h0000_7F0C, 32'hFFFF_FFFF, 4'hF, 32'h5A5A_5A5A, 4'h0, 32'h0};
    tbl[10] = '{32'h0000_7F10, 32'hFFFF_FFFF, 4'hF, 32'h5A5A_5A5A, 4'h0, 32'h0};
    tbl[11] = '{32'h0000_7EFC, 32'hFFFF_FFFF, 4'hF, 32'h5A5A_5A5A, 4'h0, 32'h0};
    tbl[12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 32'h5A5A_5A5A, 4'h0, 32'h0};

    idle_bus();
    dm_rdata = 32'h0;

    // Reset state, with decode still live while reset is held
    cpu_addr = 32'h0000_0010; cpu_byteen = 4'hF;
    #3;
    check("reset irq", {31'b0, irq}, 32'h0);
    check("reset dm_byteen", {28'b0, dm_byteen}, 32'hF);
    check_regs_zero("reset");
    apply_reset();

    // Decode / pass-through table
    for (int i = 0; i < 13; i++) begin
      cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
      cpu_byteen = tbl[i].be; dm_rdata = tbl[i].dmr;
      #1;
      check($sformatf("tbl%0d byteen", i), {28'b0, dm_byteen}, {28'b0, tbl[i].exp_be});
      check($sformatf("tbl%0d rdata", i), cpu_rdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d dm_addr", i), dm_addr, tbl[i].addr);
      check($sformatf("tbl%0d dm_wdata", i), dm_wdata, tbl[i].wdata);
      step(1);
    end
    idle_bus();
    step(1);

    // Randomized accesses; timer writes keep EN clear so COUNT stays at 0
    ctrl_m = 4'h0; preset_m = 32'h0;
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic in_dm, in_tmr;
      logic [31:0] a, d, r, e;
      logic [3:0] be;
      kind = $urandom_range(0, 2);
      if (kind == 0) a = $urandom_range(32'h2FFF, 0);
      else if (kind == 1) begin
        case ($urandom_range(0, 2))
          0: a = $urandom_range(32'h7EFF, 32'h3000);
          1: a = $urandom_range(32'h7F0F, 32'h7F0C);
          default: a = $urandom_range(32'hFFFF_FFFF, 32'h8000);
        endcase
      end else a = TMR + $urandom_range(0, 11);
      d = $urandom;
      if (kind == 2) d[0] = 1'b0;
      be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      r = $urandom;
      in_dm  = (a <= 32'h2FFF);
      in_tmr = (a >= 32'h7F00) && (a <= 32'h7F0B);
      if (in_dm) e = r;
      else if (in_tmr) begin
        case ((a - TMR) / 4)
          0: e = {28'h0, ctrl_m};
          1: e = preset_m;
          default: e = 32'h0;
        endcase
      end else e = 32'h0;
      exp_q.push_back(e);
      cpu_addr = a; cpu_wdata = d; cpu_byteen = be; dm_rdata = r;
      #1;
      check("rnd rdata", cpu_rdata, exp_q.pop_front());
      check("rnd byteen", {28'b0, dm_byteen}, in_dm ? {28'b0, be} : 32'h0);
      check("rnd dm_addr", dm_addr, a);
      check("rnd dm_wdata", dm_wdata, d);
      check("rnd irq", {31'b0, irq}, 32'h0);
      step(1);
      if (in_tmr && be == 4'hF) begin
        if ((a - TMR) / 4 == 0) ctrl_m = d[3:0];
        else if ((a - TMR) / 4 == 1) preset_m = d;
      end
    end
    idle_bus();
    apply_reset();

    // One-shot: PRESET=3, CTRL=EN|IM; write of CTRL is edge 0
    cpu_write(TMR + 4, 32'd3, 4'hF);
    cpu_write(TMR, 32'h9, 4'hF);
    step(1);
    for (int k = 2; k <= 5; k++) begin
      step(1);
      read_tmr(2'd2, v);
      check($sformatf("oneshot count e%0d", k), v, 32'(5 - k));
      check($sformatf("oneshot irq e%0d", k), {31'b0, irq}, (k >= 5) ? 32'h1 : 32'h0);
    end
    step(1);
    read_tmr(2'd0, v); check("oneshot ctrl after", v, 32'h8);
    check("oneshot irq held", {31'b0, irq}, 32'h1);
    step(3);
    check("oneshot irq held2", {31'b0, irq}, 32'h1);
    cpu_write(TMR, 32'h8, 4'hF);
    check("oneshot irq cleared", {31'b0, irq}, 32'h0);

    // Ignored writes
    cpu_write(TMR, 32'hF, 4'b0011);
    read_tmr(2'd0, v); check("partial ctrl", v, 32'h8);
    cpu_write(TMR + 4, 32'h55, 4'b1110);
    read_tmr(2'd1, v); check("partial preset", v, 32'h3);
    cpu_write(TMR + 8, 32'h1234, 4'hF);
    read_tmr(2'd2, v); check("count write", v, 32'h0);
    read_tmr(2'd3, v); check("offset c read", v, 32'h0);

    // Auto-reload with IM: pulses after edges 4, 8, 12
    cpu_write(TMR + 4, 32'd2, 4'hF);
    cpu_write(TMR, 32'hB, 4'hF);
    for (int k = 1; k <= 13; k++) begin
      step(1);
      exp_q.push_back((k >= 4 && (k % 4) == 0) ? 32'h1 : 32'h0);
      check($sformatf("reload irq e%0d", k), {31'b0, irq}, exp_q.pop_front());
    end
    cpu_write(TMR, 32'h0, 4'hF);
    step(6);

    // Auto-reload with IM=0: irq stays low, COUNT keeps cycling 2,1,0,0
    cpu_write(TMR, 32'h3, 4'hF);
    for (int k = 1; k <= 13; k++) begin
      step(1);
      check($sformatf("masked irq e%0d", k), {31'b0, irq}, 32'h0);
      if (k >= 2) begin
        logic [31:0] ec;
        case ((k - 2) % 4)
          0: ec = 32'd2;
          1: ec = 32'd1;
          default: ec = 32'd0;
        endcase
        read_tmr(2'd2, v);
        check($sformatf("masked count e%0d", k), v, ec);
      end
    end
    cpu_write(TMR, 32'h0, 4'hF);
    step(6);

    // Disable mid-count at COUNT=5; PRESET rewrite mid-run only shows on next LOAD
    cpu_write(TMR + 4, 32'd10, 4'hF);
    cpu_write(TMR, 32'h1, 4'hF);
    step(3);
    cpu_write(TMR + 4, 32'd50, 4'hF);
    read_tmr(2'd2, v); check("mid preset write count", v, 32'd8);
    step(2);
    read_tmr(2'd2, v); check("count e6", v, 32'd6);
    cpu_write(TMR, 32'h0, 4'hF);
    read_tmr(2'd2, v); check("count e7", v, 32'd5);
    step(4);
    read_tmr(2'd2, v); check("count frozen", v, 32'd5);
    cpu_write(TMR, 32'h1, 4'hF);
    step(1);
    read_tmr(2'd2, v); check("reenable load pending", v, 32'd5);
    step(1);
    read_tmr(2'd2, v); check("reenable loaded", v, 32'd50);
    step(1);
    read_tmr(2'd2, v); check("reenable dec", v, 32'd49);
    cpu_write(TMR, 32'h0, 4'hF);
    step(4);

    // PRESET=0 fires after edge 3; a PRESET write on that same edge loses to the set
    cpu_write(TMR + 4, 32'd0, 4'hF);
    cpu_write(TMR, 32'h9, 4'hF);
    step(2);
    check("zero preset irq e2", {31'b0, irq}, 32'h0);
    cpu_write(TMR + 4, 32'd0, 4'hF);
    check("zero preset set wins", {31'b0, irq}, 32'h1);
    #2; reset = 1'b0; #1;
    check("async reset irq", {31'b0, irq}, 32'h0);
    step(1);
    reset = 1'b1;
    step(1);

    // Reset mid-count at COUNT=7
    cpu_write(TMR + 4, 32'd20, 4'hF);
    cpu_write(TMR, 32'h9, 4'hF);
    step(15);
    read_tmr(2'd2, v); check("pre-reset count", v, 32'd7);
    #1; reset = 1'b0; #1;
    check("midcount reset irq", {31'b0, irq}, 32'h0);
    check_regs_zero("midcount reset");
    step(1);
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step(1);
      check("post reset irq", {31'b0, irq}, 32'h0);
    end
    check_regs_zero("post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
